// File: rtl/imm_encoder_pkg.sv
// Shared codes for the immediate encoder: extender format selects, opcodes, FSM states.
// Format-select values match the immediate extender's one-hot EXTOp encoding.
package imm_encoder_pkg;

    localparam logic [5:0] EXT_CTRL_ITYPE_SHAMT = 6'b100000;
    localparam logic [5:0] EXT_CTRL_ITYPE       = 6'b010000;
    localparam logic [5:0] EXT_CTRL_STYPE       = 6'b001000;
    localparam logic [5:0] EXT_CTRL_BTYPE       = 6'b000100;
    localparam logic [5:0] EXT_CTRL_UTYPE       = 6'b000010;
    localparam logic [5:0] EXT_CTRL_JTYPE       = 6'b000001;

    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [2:0] FUNCT3_ADDI = 3'b000;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_LI_PEND = 1'b1
    } enc_state_e;

    function automatic logic fits_signed12(input logic [31:0] v);
        return v[31:12] == {20{v[11]}};
    endfunction

endpackage

// File: rtl/imm_field_pack.sv
// Combinational packing of an immediate into RISC-V instruction fields plus range check.
// Unknown format selects fall back to R-type with no range error.
module imm_field_pack
    import imm_encoder_pkg::*;
(
    input  logic [5:0]  ext_op,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        range_err
);

    always_comb begin
        instr     = {funct7, rs2, rs1, funct3, rd, opcode};
        range_err = 1'b0;
        case (ext_op)
            EXT_CTRL_ITYPE_SHAMT: begin
                instr     = {funct7, imm[4:0], rs1, funct3, rd, opcode};
                range_err = imm[31:5] != '0;
            end
            EXT_CTRL_ITYPE: begin
                instr     = {imm[11:0], rs1, funct3, rd, opcode};
                range_err = !fits_signed12(imm);
            end
            EXT_CTRL_STYPE: begin
                instr     = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                range_err = !fits_signed12(imm);
            end
            EXT_CTRL_BTYPE: begin
                instr     = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                range_err = imm[0] | (imm[31:13] != {19{imm[12]}});
            end
            EXT_CTRL_UTYPE: begin
                instr     = {imm[31:12], rd, opcode};
                range_err = imm[11:0] != '0;
            end
            EXT_CTRL_JTYPE: begin
                instr     = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                range_err = imm[0] | (imm[31:21] != {11{imm[20]}});
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder top: request/response handshake, LI expansion FSM, output register.
// Optional saturating range-error counter enabled by defining IMM_ENC_ERRCNT_EN.
//
//   state      | meaning
//   ST_IDLE    | accepting requests; output register free or draining
//   ST_LI_PEND | LUI beat of a 2-beat LI held at output, ADDI waiting in pend_q
module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter int ERRCNT_W = 16
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [5:0]          EXTOp,
    input  logic                li,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic [6:0]          funct7,
    input  logic [4:0]          rd,
    input  logic [4:0]          rs1,
    input  logic [4:0]          rs2,
    input  logic [31:0]         imm,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         instr,
    output logic                out_last,
    output logic                range_err
`ifdef IMM_ENC_ERRCNT_EN
    ,output logic [ERRCNT_W-1:0] err_count
`endif
);

    enc_state_e  state_q, state_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic        last_q, last_d;
    logic        err_q, err_d;
    logic [31:0] pend_q, pend_d;

    logic [31:0] pack_instr;
    logic        pack_err;
    logic        accept;
    logic        li_fits, li_two;
    logic [19:0] li_hi;
    logic [31:0] li_addi_x0, li_lui, li_addi_rd;
    logic [31:0] new_instr;
    logic        new_last, new_err;

    imm_field_pack u_pack (
        .ext_op    (EXTOp),
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7    (funct7),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .imm       (imm),
        .instr     (pack_instr),
        .range_err (pack_err)
    );

    // hi is rounded up when the low 12 bits will be sign-extended negative by ADDI
    always_comb begin
        li_fits    = fits_signed12(imm);
        li_hi      = imm[31:12] + {19'd0, imm[11]};
        li_two     = !li_fits && (imm[11:0] != '0);
        li_addi_x0 = {imm[11:0], 5'd0, FUNCT3_ADDI, rd, OPC_OPIMM};
        li_lui     = {li_hi, rd, OPC_LUI};
        li_addi_rd = {imm[11:0], rd, FUNCT3_ADDI, rd, OPC_OPIMM};
        new_instr  = li ? (li_fits ? li_addi_x0 : li_lui) : pack_instr;
        new_last   = li ? !li_two : 1'b1;
        new_err    = li ? 1'b0 : pack_err;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (accept && li && li_two) state_d = ST_LI_PEND;
            ST_LI_PEND: if (out_ready)              state_d = ST_IDLE;
            default:                                state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == ST_IDLE) && (!valid_q || out_ready);
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        last_d  = last_q;
        err_d   = err_q;
        pend_d  = pend_q;
        if (state_q == ST_LI_PEND) begin
            if (out_ready) begin
                valid_d = 1'b1;
                instr_d = pend_q;
                last_d  = 1'b1;
                err_d   = 1'b0;
            end
        end else if (accept) begin
            valid_d = 1'b1;
            instr_d = new_instr;
            last_d  = new_last;
            err_d   = new_err;
            pend_d  = li_addi_rd;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            pend_q  <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            last_q  <= last_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
        end
    end

    assign out_valid = valid_q;
    assign instr     = instr_q;
    assign out_last  = last_q;
    assign range_err = err_q;

`ifdef IMM_ENC_ERRCNT_EN
    logic [ERRCNT_W-1:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst)
            err_cnt_q <= '0;
        else if (valid_q && out_ready && err_q && !(&err_cnt_q))
            err_cnt_q <= err_cnt_q + 1'b1;
    end

    assign err_count = err_cnt_q;
`else
    logic [ERRCNT_W-1:0] unused_errcnt_w;
    assign unused_errcnt_w = '0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: directed vectors plus legal-immediate round-trip
// through an independent extender model; monitor pops expectations on each output handshake.
module tb_imm_encoder;
    import imm_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [5:0]  EXTOp;
    logic        li;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        out_valid, out_ready;
    logic [31:0] instr;
    logic        out_last, range_err;
`ifdef IMM_ENC_ERRCNT_EN
    logic [15:0] err_count;
`endif

    imm_encoder #(.ERRCNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .EXTOp(EXTOp), .li(li), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .instr(instr),
        .out_last(out_last), .range_err(range_err)
`ifdef IMM_ENC_ERRCNT_EN
        , .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    // kind 0: exact instr/last/err; 1: round-trip through extender; 2: err/last only
    typedef struct {
        int          kind;
        logic [5:0]  ext;
        logic [31:0] imm;
        logic [31:0] instr;
        logic        last;
        logic        err;
        logic [6:0]  opc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   exp_errs = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] extend(input logic [5:0] ext, input logic [31:0] w);
        case (ext)
            EXT_CTRL_ITYPE_SHAMT: return {27'd0, w[24:20]};
            EXT_CTRL_ITYPE:       return {{20{w[31]}}, w[31:20]};
            EXT_CTRL_STYPE:       return {{20{w[31]}}, w[31:25], w[11:7]};
            EXT_CTRL_BTYPE:       return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            EXT_CTRL_UTYPE:       return {w[31:12], 12'd0};
            EXT_CTRL_JTYPE:       return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default:              return 32'd0;
        endcase
    endfunction

    task automatic push(input int kind, input logic [5:0] ext, input logic [31:0] im,
                        input logic [31:0] ins, input logic last, input logic err, input logic [6:0] opc);
        exp_t e;
        e.kind = kind; e.ext = ext; e.imm = im; e.instr = ins; e.last = last; e.err = err; e.opc = opc;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_beat: got %h expected none", instr);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.err) exp_errs++;
                case (e.kind)
                    0: begin
                        chk("instr", instr, e.instr);
                        chk("last", {31'd0, out_last}, {31'd0, e.last});
                        chk("err", {31'd0, range_err}, {31'd0, e.err});
                    end
                    1: begin
                        chk("roundtrip", extend(e.ext, instr), e.imm);
                        chk("rt_opcode", {25'd0, instr[6:0]}, {25'd0, e.opc});
                        chk("rt_err", {31'd0, range_err}, 32'd0);
                    end
                    default: begin
                        chk("err_only", {31'd0, range_err}, {31'd0, e.err});
                        chk("err_last", {31'd0, out_last}, {31'd0, e.last});
                    end
                endcase
            end
        end
    end

    task automatic send(input logic l, input logic [5:0] ext, input logic [6:0] opc,
                        input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im);
        int n = 0;
        in_valid = 1'b1; li = l; EXTOp = ext; opcode = opc; funct3 = f3; funct7 = f7;
        rd = d; rs1 = s1; rs2 = s2; imm = im;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                tests++; fails++;
                $display("FAIL send_timeout: got in_ready=0 expected 1");
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 500) begin
            tests++; fails++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r, v;
        logic [5:0]  fmts [6];
        fmts[0] = EXT_CTRL_ITYPE_SHAMT; fmts[1] = EXT_CTRL_ITYPE; fmts[2] = EXT_CTRL_STYPE;
        fmts[3] = EXT_CTRL_BTYPE;       fmts[4] = EXT_CTRL_UTYPE; fmts[5] = EXT_CTRL_JTYPE;

        rst = 1'b1; in_valid = 1'b0; li = 1'b0; EXTOp = '0; opcode = '0; funct3 = '0;
        funct7 = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_last", {31'd0, out_last}, 32'd0);
        chk("rst_err", {31'd0, range_err}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef IMM_ENC_ERRCNT_EN
        chk("rst_errcnt", {16'd0, err_count}, 32'd0);
`endif
        @(posedge clk); #1;

        // ITYPE vector with latency check
        push(0, EXT_CTRL_ITYPE, 0, 32'h80030293, 1'b1, 1'b0, 0);
        send(0, EXT_CTRL_ITYPE, 7'b0010011, 3'd0, 7'd0, 5'd5, 5'd6, 5'd0, 32'hFFFFF800);
        @(negedge clk);
        chk("latency1", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;

        push(0, EXT_CTRL_STYPE, 0, 32'hFE512E23, 1'b1, 1'b0, 0);
        send(0, EXT_CTRL_STYPE, 7'b0100011, 3'd2, 7'd0, 5'd0, 5'd2, 5'd5, 32'hFFFFFFFC);
        push(0, 6'b000000, 0, 32'h403100B3, 1'b1, 1'b0, 0);
        send(0, 6'b000000, 7'b0110011, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 32'hDEADBEEF);
        push(2, 0, 0, 0, 1'b1, 1'b1, 0);
        send(0, EXT_CTRL_BTYPE, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'h00000801);
        push(2, 0, 0, 0, 1'b1, 1'b1, 0);
        send(0, EXT_CTRL_JTYPE, 7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h00100000);
        push(2, 0, 0, 0, 1'b1, 1'b1, 0);
        send(0, EXT_CTRL_ITYPE, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd1, 5'd0, 32'h00000800);
        push(2, 0, 0, 0, 1'b1, 1'b0, 0);
        send(0, EXT_CTRL_ITYPE, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd1, 5'd0, 32'h000007FF);
        push(2, 0, 0, 0, 1'b1, 1'b1, 0);
        send(0, EXT_CTRL_ITYPE_SHAMT, 7'b0010011, 3'd1, 7'd0, 5'd1, 5'd1, 5'd0, 32'h00000020);
        push(2, 0, 0, 0, 1'b1, 1'b1, 0);
        send(0, EXT_CTRL_UTYPE, 7'b0110111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h00001001);

        // LI expansions
        push(0, 0, 0, 32'h123460B7, 1'b0, 1'b0, 0);
        push(0, 0, 0, 32'hFFF08093, 1'b1, 1'b0, 0);
        send(1, 6'b111111, 7'h7F, 3'd7, 7'h7F, 5'd1, 5'd9, 5'd9, 32'h12345FFF);
        push(0, 0, 0, 32'h00003137, 1'b1, 1'b0, 0);
        send(1, 6'b111111, 7'h7F, 3'd7, 7'h7F, 5'd2, 5'd9, 5'd9, 32'h00003000);
        push(0, 0, 0, 32'h00500113, 1'b1, 1'b0, 0);
        send(1, 6'b111111, 7'h7F, 3'd7, 7'h7F, 5'd2, 5'd9, 5'd9, 32'h00000005);
        drain();

        // Stall mid-LI
        out_ready = 1'b0;
        push(0, 0, 0, 32'h123460B7, 1'b0, 1'b0, 0);
        push(0, 0, 0, 32'hFFF08093, 1'b1, 1'b0, 0);
        send(1, 6'b0, 7'h0, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 32'h12345FFF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_instr", instr, 32'h123460B7);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();

        // Reset while LI_PEND: the ADDI must never appear
        out_ready = 1'b0;
        push(0, 0, 0, 32'h123460B7, 1'b0, 1'b0, 0);
        send(1, 6'b0, 7'h0, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 32'h12345FFF);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_addi", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk); #1;
        exp_errs = 0;

        // Error beat after reset for counter, then random legal round-trips
        push(2, 0, 0, 0, 1'b1, 1'b1, 0);
        send(0, EXT_CTRL_BTYPE, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'h00000003);
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < 2000; k++) begin
                r = $urandom;
                case (f)
                    0: v = {27'd0, r[4:0]};
                    1, 2: v = {{20{r[11]}}, r[11:0]};
                    3: v = {{19{r[12]}}, r[12:1], 1'b0};
                    4: v = {r[31:12], 12'd0};
                    default: v = {{11{r[20]}}, r[20:1], 1'b0};
                endcase
                push(1, fmts[f], v, 0, 1'b1, 1'b0, r[31:25]);
                send(0, fmts[f], r[31:25], r[14:12], r[11:5], r[19:15], r[24:20], r[4:0], v);
            end
        end
        drain();
`ifdef IMM_ENC_ERRCNT_EN
        chk("err_count", {16'd0, err_count}, exp_errs);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
